// File: rtl/uart_rx_core.sv
// UART receive front end: 2-flop synchronizer, 8N1 deframer with a mid-bit sampling
// counter, a one-entry valid/ready holding register, and sticky framing/overrun flags.
module uart_rx_core #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 rx,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] rate,
    input  logic                 err_clear,
    output logic [7:0]           data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 rts
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [DIV_WIDTH-1:0] RATE_MIN = DIV_WIDTH'(32'd4);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(32'd1);
    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = DIV_WIDTH'(32'd0);

    // A set event in the same cycle as a clear keeps the flag set.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        sticky_next = set | (cur & ~clr);
    endfunction

    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 rx_d_q;

    logic [2:0]           state_q,   state_d;
    logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
    logic [DIV_WIDTH-1:0] rate_l_q,  rate_l_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q,   shift_d;

    logic [7:0]           data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 busy_q,      busy_d;
    logic                 rts_q,       rts_d;

    logic                 fall_s;
    logic                 tick_s;
    logic [DIV_WIDTH-1:0] rate_eff_s;
    logic                 deliver_s;
    logic                 ferr_s;
    logic                 ovr_set_s;

    assign fall_s     = rx_d_q & ~rx_s_q;
    assign tick_s     = (cnt_q == CNT_ZERO);
    assign rate_eff_s = (rate < RATE_MIN) ? RATE_MIN : rate;

    // Synchronizer and edge-detect history; idle-high so reset never looks like a start.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    // Deframing FSM, bit-period counter and shift register next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rate_l_d  = rate_l_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;

        if (state_q != ST_IDLE) begin
            if (tick_s) begin
                cnt_d = rate_l_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_d  = ST_START;
                        rate_l_d = rate_eff_s;
                        cnt_d    = (rate_eff_s >> 1) - CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (!rx_s_q) begin
                            state_d   = ST_DATA;
                            bit_idx_d = 3'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (rx_s_q) begin
                            deliver_s = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            ferr_s  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_BREAK: begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Holding register, handshake, sticky flags and status next-state logic.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_set_s = 1'b0;

        if (deliver_s) begin
            valid_d = 1'b1;
            if (valid_q && !ready) begin
                ovr_set_s = 1'b1;
            end else begin
                data_d = shift_q;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        frame_err_d = sticky_next(frame_err_q, ferr_s, err_clear);
        overrun_d   = sticky_next(overrun_q, ovr_set_s, err_clear);
        busy_d      = (state_d != ST_IDLE);
        rts_d       = ~(en & ~valid_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            rate_l_q    <= RATE_MIN;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            rts_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rate_l_q    <= rate_l_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            rts_q       <= rts_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
    assign rts       = rts_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level reference model (event times derived from the bit
// timing rules) compared every cycle, plus directed checks with hand-computed values.
module tb_uart_rx_core;
    localparam int DW = 16;
    localparam int K_GOOD = 0, K_FERR = 1, K_GLITCH = 2;

    logic          clk = 1'b0, nReset = 1'b0, rx = 1'b1, en = 1'b0;
    logic          err_clear = 1'b0, ready = 1'b0;
    logic [DW-1:0] rate = 16'd16;
    logic [7:0]    data;
    logic          valid, frame_err, overrun, busy, rts;

    uart_rx_core #(.DIV_WIDTH(DW)) dut (
        .clk(clk), .nReset(nReset), .rx(rx), .en(en), .rate(rate),
        .err_clear(err_clear), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy), .rts(rts)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int edge_n = 0;

    // Pending frame record: edges (posedge numbers) at which its effects become visible.
    bit         f_active = 1'b0;
    int         f_on = 0, f_stop = -1, f_end = 0, f_kind = 0;
    logic [7:0] f_byte = 8'h00;

    logic [7:0] m_data = 8'h00;
    bit m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_busy = 1'b0, m_rts = 1'b1;
    bit rand_mode = 1'b0;
    bit prev_valid = 1'b0;
    int rise_edge = -1;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: applies frame events at their scheduled edges, then the handshake.
    always @(posedge clk) begin
        bit deliver, fe_set, ov_set;
        edge_n++;
        deliver = 1'b0;
        fe_set  = 1'b0;
        if (!nReset) begin
            m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            m_busy = 1'b0;  m_rts = 1'b1;   f_active = 1'b0;
        end else begin
            if (!en) begin
                m_busy   = 1'b0;
                f_active = 1'b0;
            end else if (f_active) begin
                if (edge_n == f_on) m_busy = 1'b1;
                if (edge_n == f_stop && f_kind == K_GOOD) deliver = 1'b1;
                if (edge_n == f_stop && f_kind == K_FERR) fe_set = 1'b1;
                if (edge_n == f_end) begin
                    m_busy   = 1'b0;
                    f_active = 1'b0;
                end
            end
            ov_set = deliver && m_valid && !ready;
            if (deliver) begin
                if (!ov_set) m_data = f_byte;
                m_valid = 1'b1;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            m_fe  = fe_set | (m_fe & !err_clear);
            m_ov  = ov_set | (m_ov & !err_clear);
            m_rts = !(en && !m_valid);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (nReset) begin
            chk1("valid", valid, m_valid);
            if (m_valid) chk8("data", data, m_data);
            chk1("frame_err", frame_err, m_fe);
            chk1("overrun", overrun, m_ov);
            chk1("busy", busy, m_busy);
            chk1("rts", rts, m_rts);
            if (valid && !prev_valid) rise_edge = edge_n;
        end
        prev_valid = valid;
    end

    task automatic wait_neg(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_mode) begin
                ready     = ($urandom_range(0, 3) == 0);
                err_clear = ($urandom_range(0, 15) == 0);
            end
        end
    endtask

    // Register the frame about to start; E is the first edge that samples the start bit.
    task automatic start_record(input logic [7:0] b, input logic stop_bit, input int r, output int E);
        int re, h;
        re = (r < 4) ? 4 : r;
        h  = re / 2;
        E  = edge_n + 1;
        f_on   = E + 2;
        f_stop = E + 2 + h + 9 * re;
        f_kind = stop_bit ? K_GOOD : K_FERR;
        f_byte = b;
        f_end  = stop_bit ? f_stop : 32'h3fffffff;
        f_active = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input int r,
                        input int brk_low, input int abort_slot, output int E);
        int re;
        logic bitval;
        re   = (r < 4) ? 4 : r;
        rate = DW'(r);
        start_record(b, stop_bit, r, E);
        for (int slot = 0; slot < 10; slot++) begin
            bitval = (slot == 0) ? 1'b0 : (slot == 9) ? stop_bit : b[slot-1];
            rx = bitval;
            if (slot == 2) rate = DW'($urandom_range(0, 40));
            if (slot == abort_slot) begin
                wait_neg(re / 2);
                en = 1'b0;
                wait_neg(1);
                chk1("abort_busy", busy, 1'b0);
                wait_neg(re - re / 2 - 1);
            end else begin
                wait_neg(re);
            end
        end
        if (abort_slot >= 0) en = 1'b1;
        if (!stop_bit) begin
            wait_neg(brk_low);
            rx    = 1'b1;
            f_end = edge_n + 3;
        end
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        wait_neg(1);
        ready = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        wait_neg(1);
        err_clear = 1'b0;
    endtask

    initial begin
        int E, r, gap;
        logic [7:0] b;
        logic st;

        wait_neg(3);
        nReset = 1'b1;
        wait_neg(1);
        chk8("rst_data", data, 8'h00);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_fe", frame_err, 1'b0);
        chk1("rst_ov", overrun, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rts", rts, 1'b1);
        en = 1'b1;
        wait_neg(4);

        // 0xA5 at rate 16, consumer stalled.
        rise_edge = -1;
        send(8'hA5, 1'b1, 16, 0, -1, E);
        chk_int("a5_latency", rise_edge - E, 154);
        chk8("a5_data", data, 8'hA5);
        chk1("a5_valid", valid, 1'b1);
        chk1("a5_fe", frame_err, 1'b0);
        chk1("a5_ov", overrun, 1'b0);
        chk1("a5_rts", rts, 1'b1);

        pulse_ready();
        chk1("hs_valid", valid, 1'b0);
        chk1("hs_rts", rts, 1'b0);
        wait_neg(3);
        send(8'h3C, 1'b1, 16, 0, -1, E);
        chk8("3c_data", data, 8'h3C);
        chk1("3c_valid", valid, 1'b1);
        pulse_ready();

        // Back-to-back with the holding register full.
        wait_neg(3);
        send(8'h11, 1'b1, 16, 0, -1, E);
        send(8'h22, 1'b1, 16, 0, -1, E);
        chk8("ovr_data", data, 8'h11);
        chk1("ovr_flag", overrun, 1'b1);
        pulse_clear();
        chk1("ovr_clear", overrun, 1'b0);
        pulse_ready();

        // Stop bit low followed by a 40-cycle break.
        wait_neg(3);
        send(8'h55, 1'b0, 16, 40, -1, E);
        chk1("brk_busy", busy, 1'b1);
        chk1("brk_fe", frame_err, 1'b1);
        chk1("brk_valid", valid, 1'b0);
        wait_neg(4);
        chk1("brk_exit_busy", busy, 1'b0);
        send(8'h0F, 1'b1, 16, 0, -1, E);
        chk8("0f_data", data, 8'h0F);
        chk1("0f_valid", valid, 1'b1);
        pulse_clear();
        pulse_ready();

        // Three-cycle glitch on an idle line.
        wait_neg(3);
        rate   = 16'd16;
        E      = edge_n + 1;
        f_on   = E + 2;
        f_end  = E + 2 + 8;
        f_stop = -1;
        f_kind = K_GLITCH;
        f_active = 1'b1;
        rx = 1'b0;
        wait_neg(3);
        rx = 1'b1;
        wait_neg(15);
        chk1("gl_valid", valid, 1'b0);
        chk1("gl_fe", frame_err, 1'b0);
        chk1("gl_busy", busy, 1'b0);

        // Receiver disabled during data bit 4.
        send(8'hC3, 1'b1, 16, 0, 5, E);
        wait_neg(5);
        chk1("abort_valid", valid, 1'b0);

        // Random frames, rates (including below the minimum) and consumer behaviour.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b   = 8'($urandom);
            r   = $urandom_range(2, 20);
            st  = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(3, 8);
            send(b, st, r, $urandom_range(0, 20), -1, E);
            wait_neg(gap);
        end
        rand_mode = 1'b0;
        ready     = 1'b0;
        err_clear = 1'b0;
        wait_neg(3);

        // Asynchronous reset in the middle of a frame.
        rate = 16'd16;
        start_record(8'h99, 1'b1, 16, E);
        rx = 1'b0;
        wait_neg(16);
        rx = 1'b1;
        wait_neg(16);
        rx = 1'b0;
        wait_neg(10);
        chk1("pre_rst_busy", busy, 1'b1);
        nReset = 1'b0;
        #1;
        chk8("arst_data", data, 8'h00);
        chk1("arst_valid", valid, 1'b0);
        chk1("arst_fe", frame_err, 1'b0);
        chk1("arst_ov", overrun, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_rts", rts, 1'b1);
        wait_neg(3);
        rx = 1'b1;
        wait_neg(2);
        nReset = 1'b1;
        wait_neg(5);
        chk1("post_rst_rts", rts, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
